dm_dma_arbiter: RTL and testbench
=================================

Name: dm_dma_arbiter

Overview:
- Shares the single-port internal data memory between the core (program sequencer / DAG side) and a block-transfer DMA channel.
- Core accesses pass straight through with absolute priority. The DMA channel is sequenced into idle memory cycles by an address/length engine.
- The block owns the memory write-data bus and honours the memory's write-at-execute+1 data timing.
- Sits between the core/DMA front-ends and the memory_int instance.

Parameters:
DMA_SIZE, 3, memory address width (depth 2**DMA_SIZE)
DMD_SIZE, 4, memory data width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps_dm_cslt  in  1  core chip select
ps_dm_wrb  in  1  core write (1) / read (0)
dg_dm_add  in  DMA_SIZE  core address
ps_bc_dt  in  DMD_SIZE  core write data, valid the cycle after core write command
dma_start  in  1  start pulse, sampled in IDLE only
dma_dir  in  1  1 = stream into memory, 0 = memory to stream
dma_base  in  DMA_SIZE  first address
dma_len  in  DMA_SIZE+1  word count, 0..2**DMA_SIZE
dma_wr_dt  in  DMD_SIZE  write stream data
dma_wr_vld  in  1  write stream valid
dma_wr_rdy  out  1  write stream ready
dma_rd_dt  out  DMD_SIZE  read stream data
dma_rd_vld  out  1  read stream valid, single-cycle, no backpressure
dma_busy  out  1  transfer in progress
dma_done  out  1  one-cycle completion pulse
mem_cslt  out  1  to memory chip select
mem_wrb  out  1  to memory read/write
mem_add  out  DMA_SIZE  to memory address
mem_dt  out  DMD_SIZE  to memory write data
dm_bc_dt  in  DMD_SIZE  memory read data, valid the cycle after a read command

Behaviour:
Memory contract:
- A read issued in cycle N returns data on dm_bc_dt in N+1.
- A write command latched in N writes mem_dt sampled in N+1.
- The memory keeps rewriting its last latched write address every cycle, so mem_dt must hold the last write value indefinitely once its data cycle has passed.

Reset values: all outputs 0; state IDLE; mem_dt hold register 0.

Arbitration (combinational):
- If ps_dm_cslt=1, mem_cslt/mem_wrb/mem_add are the core values.
- Otherwise they come from the DMA issue, if any.
- Fixed priority; the core is never stalled, so DMA may starve.

Write data:
- wr_owner is registered from the cycle-N write issue.
- In N+1, mem_dt = ps_bc_dt for a core write, or the DMA data register for a DMA write. The hold register captures that value.
- In all other cycles mem_dt = hold register.

FSM:
- IDLE: on dma_start, latch base, len and dir into addr/cnt/dir registers and go to RUN. If len=0, go to DRAIN instead, with no accesses.
- RUN, issue conditions: ~ps_dm_cslt and cnt!=0. For a write, additionally dma_wr_vld.
- RUN, write handshake: dma_wr_rdy = RUN & dir & ~ps_dm_cslt & cnt!=0. On a handshake, capture dma_wr_dt into the DMA data register.
- RUN, on each issue: addr increments modulo 2**DMA_SIZE (wraps 7->0 at default); cnt decrements.
- RUN, on the issue that makes cnt reach 0: go to DRAIN.
- DRAIN: one cycle; covers the last write-data or read-return cycle. dma_done=1 in this cycle, then go to IDLE.
- dma_busy = (state != IDLE).
- dma_start outside IDLE is ignored.

Read return:
- dma_rd_vld registered 1 when the previous cycle issued a DMA read.
- dma_rd_dt = dm_bc_dt.
- Core read data is not routed here; the core reads dm_bc_dt directly.

Simultaneous events:
- A core access in the DMA's issue cycle blocks the DMA; the DMA retries next cycle with the same addr and cnt.
- A core write in N+1 after a DMA write in N is legal. The DMA data is still presented in N+1; the core data follows in N+2.

Reset mid-transfer: immediate return to IDLE, counters cleared, no done pulse.

Latency: unblocked transfer of L words is done at start+L+1, busy for L+1 cycles.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state encoding localparams IDLE/RUN/DRAIN;
  - wr_owner encoding CORE/DMA.
- One natural sub-module, dm_dma_addr_gen: base/length load, wrapping address increment, count-zero flag.

Test Plan:
1. DMA write base=2, len=3, data A,B,C, core idle -> mem writes at 2,3,4 with mem_dt A,B,C one cycle after each command; done at start+4; mem_dt holds C afterwards.
2. DMA read base=6, len=4 over preloaded memory -> addresses 6,7,0,1 (wrap); rd_vld four consecutive cycles with matching data; done with the last rd_vld.
3. Core read asserted on the 2nd DMA issue cycle -> core wins, DMA address held, DMA write resumes next cycle; total done delayed by exactly 1 cycle.
4. Core write to 5 (data 9) immediately after a DMA write to 1 (data 4) -> mem[1]=4, mem[5]=9; mem_dt then holds 9.
5. dma_len=0 -> no mem_cslt; busy for 1 cycle; done pulse 1 cycle after start; start during busy ignored.
6. rst asserted mid-transfer after 2 of 5 words -> outputs 0 asynchronously, IDLE, no done; a new start after release works normally.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory / DMA arbiter: transfer sequencer states
// and the owner tag that selects who supplies write data in the data cycle.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_state_t;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } wr_owner_t;

endpackage

// File: rtl/dm_dma_arbiter_if.sv
// Bundle of core, DMA stream and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dm_dma_arbiter_if #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
);
  import dm_arb_pkg::*;

  logic                ps_dm_cslt;
  logic                ps_dm_wrb;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMD_SIZE-1:0] ps_bc_dt;
  logic                dma_start;
  logic                dma_dir;
  logic [DMA_SIZE-1:0] dma_base;
  logic [DMA_SIZE:0]   dma_len;
  logic [DMD_SIZE-1:0] dma_wr_dt;
  logic                dma_wr_vld;
  logic                dma_wr_rdy;
  logic [DMD_SIZE-1:0] dma_rd_dt;
  logic                dma_rd_vld;
  logic                dma_busy;
  logic                dma_done;
  logic                mem_cslt;
  logic                mem_wrb;
  logic [DMA_SIZE-1:0] mem_add;
  logic [DMD_SIZE-1:0] mem_dt;
  logic [DMD_SIZE-1:0] dm_bc_dt;

  modport master (
    output ps_dm_cslt, ps_dm_wrb, dg_dm_add, ps_bc_dt,
    output dma_start, dma_dir, dma_base, dma_len, dma_wr_dt, dma_wr_vld,
    output dm_bc_dt,
    input  dma_wr_rdy, dma_rd_dt, dma_rd_vld, dma_busy, dma_done,
    input  mem_cslt, mem_wrb, mem_add, mem_dt
  );

  modport slave (
    input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, ps_bc_dt,
    input  dma_start, dma_dir, dma_base, dma_len, dma_wr_dt, dma_wr_vld,
    input  dm_bc_dt,
    output dma_wr_rdy, dma_rd_dt, dma_rd_vld, dma_busy, dma_done,
    output mem_cslt, mem_wrb, mem_add, mem_dt
  );

endinterface

// File: rtl/dm_dma_addr_gen.sv
// DMA address/length engine: loads base and word count, then steps a
// wrapping address and a down-counter once per issued access.
module dm_dma_addr_gen
  import dm_arb_pkg::*;
#(
  parameter int DMA_SIZE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [DMA_SIZE-1:0] base,
  input  logic [DMA_SIZE:0]   len,
  output logic [DMA_SIZE-1:0] addr,
  output logic                cnt_zero,
  output logic                cnt_last
);

  logic [DMA_SIZE:0] cnt;

  // The address is exactly DMA_SIZE bits wide, so the increment wraps for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= len;
    end else if (step) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);
  assign cnt_last = (cnt == (DMA_SIZE+1)'(1));

endmodule

// File: rtl/dm_dma_arbiter.sv
// Single-port data memory arbiter: the core passes straight through with
// absolute priority, and a block DMA channel fills the idle memory cycles.
module dm_dma_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_dma_arbiter_if.slave       bus
);

  dma_state_t          state;
  wr_owner_t           wr_owner;
  logic                dir_q;
  logic                wr_pend;
  logic                rd_vld_q;
  logic                cnt_zero;
  logic                cnt_last;
  logic                load;
  logic                wr_rdy;
  logic                dma_issue;
  logic [DMA_SIZE-1:0] dma_addr;
  logic [DMD_SIZE-1:0] dma_dt_q;
  logic [DMD_SIZE-1:0] hold_q;
  logic [DMD_SIZE-1:0] mem_dt_w;
  logic                mem_cslt_w;
  logic                mem_wrb_w;
  logic [DMA_SIZE-1:0] mem_add_w;

  assign load      = (state == IDLE) && bus.dma_start;
  assign wr_rdy    = (state == RUN) && dir_q && !bus.ps_dm_cslt && !cnt_zero;
  assign dma_issue = (state == RUN) && !bus.ps_dm_cslt && !cnt_zero &&
                     (!dir_q || bus.dma_wr_vld);

  dm_dma_addr_gen #(.DMA_SIZE(DMA_SIZE)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (dma_issue),
    .base     (bus.dma_base),
    .len      (bus.dma_len),
    .addr     (dma_addr),
    .cnt_zero (cnt_zero),
    .cnt_last (cnt_last)
  );

  // Memory keeps rewriting its last write address, so mem_dt falls back to the
  // last written value whenever no write data cycle is in progress.
  always_comb begin
    mem_cslt_w = bus.ps_dm_cslt | dma_issue;
    mem_wrb_w  = bus.ps_dm_cslt ? bus.ps_dm_wrb : (dma_issue & dir_q);
    mem_add_w  = bus.ps_dm_cslt ? bus.dg_dm_add : dma_addr;
    mem_dt_w   = hold_q;
    if (wr_pend) begin
      mem_dt_w = (wr_owner == CORE) ? bus.ps_bc_dt : dma_dt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.dma_start) begin
          dir_q <= bus.dma_dir;
          state <= (bus.dma_len == '0) ? DRAIN : RUN;
        end
        RUN:     if (dma_issue && cnt_last) state <= DRAIN;
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-data ownership and read-return timing both trail the issue by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend  <= 1'b0;
      wr_owner <= CORE;
      dma_dt_q <= '0;
      hold_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (wr_rdy && bus.dma_wr_vld) dma_dt_q <= bus.dma_wr_dt;
      if (wr_pend) hold_q <= mem_dt_w;
      wr_pend  <= mem_cslt_w && mem_wrb_w;
      wr_owner <= bus.ps_dm_cslt ? CORE : DMA;
      rd_vld_q <= dma_issue && !dir_q;
    end
  end

  assign bus.mem_cslt   = mem_cslt_w;
  assign bus.mem_wrb    = mem_wrb_w;
  assign bus.mem_add    = mem_add_w;
  assign bus.mem_dt     = mem_dt_w;
  assign bus.dma_wr_rdy = wr_rdy;
  assign bus.dma_rd_vld = rd_vld_q;
  assign bus.dma_rd_dt  = bus.dm_bc_dt;
  assign bus.dma_busy   = (state != IDLE);
  assign bus.dma_done   = (state == DRAIN);

endmodule

// File: tb/tb_dm_dma_arbiter.sv
// Self-checking bench for dm_dma_arbiter: a transfer-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dm_dma_arbiter;

  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_dma_arbiter_if #(.DMA_SIZE(AW), .DMD_SIZE(DW)) bus ();

  dm_dma_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Write stream source: presents words from wr_words until wr_count are taken.
  logic [DW-1:0] wr_words [8];
  int wr_count = 0;
  int wr_first = 0;
  int hs_total = 0;

  always @(posedge clk) if (bus.dma_wr_vld && bus.dma_wr_rdy) hs_total <= hs_total + 1;
  assign bus.dma_wr_vld = (hs_total - wr_first) < wr_count;
  assign bus.dma_wr_dt  = wr_words[3'(hs_total - wr_first)];

  // Memory environment following the read-next-cycle / write-data-next-cycle contract.
  logic [DW-1:0] env_mem [DEPTH];
  logic [AW-1:0] env_wr_add;
  logic          env_wr_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      env_wr_valid <= 1'b0;
    end else begin
      if (env_wr_valid) env_mem[env_wr_add] <= bus.mem_dt;
      if (bus.mem_cslt && !bus.mem_wrb)
        bus.dm_bc_dt <= (env_wr_valid && env_wr_add == bus.mem_add) ? bus.mem_dt
                                                                     : env_mem[bus.mem_add];
      if (bus.mem_cslt && bus.mem_wrb) begin
        env_wr_add   <= bus.mem_add;
        env_wr_valid <= 1'b1;
      end
    end
  end

  // Reference model: a transfer is (base, len, dir, words issued so far).
  logic          m_run, m_fin, m_dir, m_rd_vld;
  int            m_base, m_len, m_issued, m_pend;
  logic [AW-1:0] m_pend_addr;
  logic [DW-1:0] m_dma_word, m_last, m_rd_data, m_val;
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_iss;

  function automatic logic exp_issue();
    return m_run && !bus.ps_dm_cslt && (m_issued < m_len) && (!m_dir || bus.dma_wr_vld);
  endfunction

  function automatic logic [AW-1:0] exp_dma_addr();
    return AW'((m_base + m_issued) % DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_fin = 0; m_dir = 0; m_rd_vld = 0;
      m_base = 0; m_len = 0; m_issued = 0; m_pend = 0;
      m_last = '0; m_dma_word = '0;
    end else begin
      m_iss = exp_issue();
      if (m_pend != 0) begin
        m_val = (m_pend == 1) ? bus.ps_bc_dt : m_dma_word;
        m_mem[m_pend_addr] = m_val;
        m_last = m_val;
      end
      m_rd_vld = m_iss && !m_dir;
      if (m_iss && !m_dir) m_rd_data = m_mem[exp_dma_addr()];
      if (bus.ps_dm_cslt && bus.ps_dm_wrb) begin
        m_pend = 1; m_pend_addr = bus.dg_dm_add;
      end else if (m_iss && m_dir) begin
        m_pend = 2; m_pend_addr = exp_dma_addr(); m_dma_word = bus.dma_wr_dt;
      end else begin
        m_pend = 0;
      end
      if (m_fin) begin
        m_fin = 0;
      end else if (m_run) begin
        if (m_iss) begin
          m_issued++;
          if (m_issued == m_len) begin m_run = 0; m_fin = 1; end
        end
      end else if (bus.dma_start) begin
        m_base = int'(bus.dma_base); m_len = int'(bus.dma_len);
        m_dir = bus.dma_dir; m_issued = 0;
        if (m_len == 0) m_fin = 1; else m_run = 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic compareLoop();
    logic core, iss;
    logic [DW-1:0] e_dt;
    forever begin
      @(negedge clk);
      if (!rst) begin
        core = bus.ps_dm_cslt;
        iss  = exp_issue();
        e_dt = (m_pend == 1) ? bus.ps_bc_dt : (m_pend == 2) ? m_dma_word : m_last;
        checkOutput("mem_cslt", 32'(bus.mem_cslt), 32'(core || iss));
        if (core || iss) begin
          checkOutput("mem_wrb", 32'(bus.mem_wrb), 32'(core ? bus.ps_dm_wrb : m_dir));
          checkOutput("mem_add", 32'(bus.mem_add), 32'(core ? bus.dg_dm_add : exp_dma_addr()));
        end
        checkOutput("mem_dt", 32'(bus.mem_dt), 32'(e_dt));
        checkOutput("dma_busy", 32'(bus.dma_busy), 32'(m_run || m_fin));
        checkOutput("dma_done", 32'(bus.dma_done), 32'(m_fin));
        checkOutput("dma_wr_rdy", 32'(bus.dma_wr_rdy), 32'(m_run && m_dir && !core && m_issued < m_len));
        checkOutput("dma_rd_vld", 32'(bus.dma_rd_vld), 32'(m_rd_vld));
        if (m_rd_vld) checkOutput("dma_rd_dt", 32'(bus.dma_rd_dt), 32'(m_rd_data));
      end
    end
  endtask

  int start_cyc = 0;
  logic [DW-1:0] rd_got [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dir, input int base, input int len);
    bus.dma_dir   = dir;
    bus.dma_base  = AW'(base);
    bus.dma_len   = (AW+1)'(len);
    bus.dma_start = 1'b1;
    start_cyc     = cyc;
  endtask

  task automatic loadWords(input int n, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2);
    wr_words[0] = w0; wr_words[1] = w1; wr_words[2] = w2;
    wr_first = hs_total;
    wr_count = n;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dma_done) begin lat = cyc - start_cyc; return; end
    end
  endtask

  task automatic collectRead(output int lat, output int n, output logic vld_at_done);
    lat = -1; n = 0; vld_at_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dma_rd_vld && n < 8) begin rd_got[n] = bus.dma_rd_dt; n++; end
      if (bus.dma_done) begin lat = cyc - start_cyc; vld_at_done = bus.dma_rd_vld; return; end
    end
  endtask

  task automatic coreWrite(input int addr, input logic [DW-1:0] val);
    bus.ps_dm_cslt = 1'b1; bus.ps_dm_wrb = 1'b1; bus.dg_dm_add = AW'(addr);
    step();
    bus.ps_dm_cslt = 1'b0; bus.ps_dm_wrb = 1'b0; bus.ps_bc_dt = val;
    step();
    bus.ps_bc_dt = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic vad;
    bus.ps_dm_cslt = 0; bus.ps_dm_wrb = 0; bus.dg_dm_add = '0; bus.ps_bc_dt = '0;
    bus.dma_start = 0; bus.dma_dir = 0; bus.dma_base = '0; bus.dma_len = '0;
    fork compareLoop(); join_none

    #1 rst = 1'b1;
    #2;
    checkOutput("reset mem_cslt", 32'(bus.mem_cslt), 0);
    checkOutput("reset mem_dt", 32'(bus.mem_dt), 0);
    checkOutput("reset dma_busy", 32'(bus.dma_busy), 0);
    checkOutput("reset dma_done", 32'(bus.dma_done), 0);
    step(); step();
    rst = 1'b0;
    step();

    $display("[TB] DMA write base 2 len 3");
    loadWords(3, 4'hA, 4'hB, 4'hC);
    applyStimulus(1'b1, 2, 3);
    step(); bus.dma_start = 1'b0;
    waitDone(lat);
    checkOutput("t1 done latency", 32'(lat), 4);
    step(); step(); step();
    @(negedge clk);
    checkOutput("t1 mem_dt hold", 32'(bus.mem_dt), 32'hC);
    checkOutput("t1 mem[2]", 32'(env_mem[2]), 32'hA);
    checkOutput("t1 mem[3]", 32'(env_mem[3]), 32'hB);
    checkOutput("t1 mem[4]", 32'(env_mem[4]), 32'hC);
    loadWords(0, '0, '0, '0);

    $display("[TB] DMA read base 6 len 4 with wrap");
    step();
    coreWrite(6, 4'h3); coreWrite(7, 4'h6); coreWrite(0, 4'h1); coreWrite(1, 4'h4);
    step();
    applyStimulus(1'b0, 6, 4);
    step(); bus.dma_start = 1'b0;
    collectRead(lat, n, vad);
    checkOutput("t2 done latency", 32'(lat), 5);
    checkOutput("t2 read count", 32'(n), 4);
    checkOutput("t2 rd[0]", 32'(rd_got[0]), 32'h3);
    checkOutput("t2 rd[1]", 32'(rd_got[1]), 32'h6);
    checkOutput("t2 rd[2]", 32'(rd_got[2]), 32'h1);
    checkOutput("t2 rd[3]", 32'(rd_got[3]), 32'h4);
    checkOutput("t2 rd_vld with done", 32'(vad), 1);

    $display("[TB] core read blocks second DMA write issue");
    step();
    loadWords(3, 4'h1, 4'h2, 4'h3);
    applyStimulus(1'b1, 0, 3);
    step(); bus.dma_start = 1'b0;
    step(); bus.ps_dm_cslt = 1'b1; bus.ps_dm_wrb = 1'b0; bus.dg_dm_add = 3'd7;
    @(negedge clk);
    checkOutput("t3 core address wins", 32'(bus.mem_add), 7);
    checkOutput("t3 wr_rdy blocked", 32'(bus.dma_wr_rdy), 0);
    step(); bus.ps_dm_cslt = 1'b0; bus.dg_dm_add = '0;
    waitDone(lat);
    checkOutput("t3 done latency", 32'(lat), 5);
    step(); step();
    @(negedge clk);
    checkOutput("t3 mem[1]", 32'(env_mem[1]), 32'h2);
    checkOutput("t3 mem[2]", 32'(env_mem[2]), 32'h3);

    $display("[TB] core write right after DMA write");
    loadWords(1, 4'h4, '0, '0);
    applyStimulus(1'b1, 1, 1);
    step(); bus.dma_start = 1'b0;
    step(); bus.ps_dm_cslt = 1'b1; bus.ps_dm_wrb = 1'b1; bus.dg_dm_add = 3'd5;
    @(negedge clk);
    checkOutput("t4 dma data in N+1", 32'(bus.mem_dt), 32'h4);
    step(); bus.ps_dm_cslt = 1'b0; bus.ps_dm_wrb = 1'b0; bus.dg_dm_add = '0; bus.ps_bc_dt = 4'h9;
    @(negedge clk);
    checkOutput("t4 core data in N+2", 32'(bus.mem_dt), 32'h9);
    step(); bus.ps_bc_dt = '0;
    step(); step();
    @(negedge clk);
    checkOutput("t4 mem_dt hold", 32'(bus.mem_dt), 32'h9);
    checkOutput("t4 mem[1]", 32'(env_mem[1]), 32'h4);
    checkOutput("t4 mem[5]", 32'(env_mem[5]), 32'h9);
    loadWords(0, '0, '0, '0);

    $display("[TB] zero-length transfer, restart while busy");
    applyStimulus(1'b0, 3, 0);
    step(); bus.dma_len = 4'd3;
    @(negedge clk);
    checkOutput("t5 busy", 32'(bus.dma_busy), 1);
    checkOutput("t5 done", 32'(bus.dma_done), 1);
    checkOutput("t5 no access", 32'(bus.mem_cslt), 0);
    step(); bus.dma_start = 1'b0;
    @(negedge clk);
    checkOutput("t5 idle after done", 32'(bus.dma_busy), 0);
    step();
    @(negedge clk);
    checkOutput("t5 restart ignored", 32'(bus.dma_busy), 0);
    checkOutput("t5 still no access", 32'(bus.mem_cslt), 0);

    $display("[TB] reset in the middle of a read transfer");
    step();
    applyStimulus(1'b0, 0, 5);
    step(); bus.dma_start = 1'b0;
    step(); step();
    #1 rst = 1'b1;
    #1;
    checkOutput("t6 mem_cslt", 32'(bus.mem_cslt), 0);
    checkOutput("t6 busy", 32'(bus.dma_busy), 0);
    checkOutput("t6 done", 32'(bus.dma_done), 0);
    checkOutput("t6 rd_vld", 32'(bus.dma_rd_vld), 0);
    checkOutput("t6 mem_dt", 32'(bus.mem_dt), 0);
    @(negedge clk);
    checkOutput("t6 no done in reset", 32'(bus.dma_done), 0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checkOutput("t6 idle after reset", 32'(bus.dma_busy), 0);
    step();
    applyStimulus(1'b0, 6, 2);
    step(); bus.dma_start = 1'b0;
    collectRead(lat, n, vad);
    checkOutput("t6 restart latency", 32'(lat), 3);
    checkOutput("t6 restart count", 32'(n), 2);
    checkOutput("t6 restart rd[0]", 32'(rd_got[0]), 32'h3);
    checkOutput("t6 restart rd[1]", 32'(rd_got[1]), 32'h6);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
